// File: rtl/div16x8_seq.sv
// Sequential unsigned restoring divider, NW-bit dividend by DW-bit divisor.
// Produces one quotient bit per cycle and uses valid/ready handshakes on both sides.
module div16x8_seq #(
  parameter int NW = 16,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [NW-1:0] n,
  input  logic [DW-1:0] d,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [NW-1:0] q,
  output logic [DW-1:0] rem,
  output logic          dz
);

  // state | meaning
  // IDLE  | waiting for operands, in_ready high
  // BUSY  | one restoring step per cycle, NW steps in total
  // DONE  | result held, out_valid high until out_ready
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int CW = $clog2(NW + 1);

  state_t          state, state_nxt;
  logic [DW-1:0]   dreg;
  logic [NW-1:0]   qs;
  logic [DW:0]     pr;
  logic [CW-1:0]   cnt;
  logic            dz_r;
  logic [DW+1:0]   trial;
  logic            accept;
  logic            last_step;

  assign accept    = in_valid && (state == IDLE);
  assign last_step = (cnt == CW'(NW - 1));
  // One extra bit on top so the borrow shows up as the sign of the trial difference
  assign trial     = {pr, qs[NW-1]} - {2'b00, dreg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (d == '0) ? DONE : BUSY;
      BUSY:    if (last_step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dreg <= '0;
      qs   <= '0;
      pr   <= '0;
      cnt  <= '0;
      dz_r <= 1'b0;
    end else if (accept) begin
      dreg <= d;
      pr   <= '0;
      cnt  <= '0;
      if (d == '0) begin
        qs   <= '1;
        dz_r <= 1'b1;
      end else begin
        qs   <= n;
        dz_r <= 1'b0;
      end
    end else if (state == BUSY) begin
      if (!trial[DW+1]) begin
        pr <= trial[DW:0];
        qs <= {qs[NW-2:0], 1'b1};
      end else begin
        pr <= {pr[DW-1:0], qs[NW-1]};
        qs <= {qs[NW-2:0], 1'b0};
      end
      cnt <= cnt + CW'(1);
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign q         = qs;
  assign rem       = pr[DW-1:0];
  assign dz        = dz_r;

endmodule
